jy_irq_source: RTL and testbench
================================

Name: jy_irq_source

Overview:
- Upstream event-conditioning stage for the J.Y. Company mapper IRQ prescaler/counter.
- Turns raw bus activity into a single registered, one-clock `irq_tick` pulse, chosen by the mapper's IRQ mode bits. Sources: CPU M2, filtered PPU A12 rise, PPU CHR read, CPU write.
- Replaces the mapper's raw combinational A12 edge detect with a low-time-filtered detector, so the counter no longer sees glitchy A12 toggles.
- Also keeps a wrapping count of delivered ticks for debug/verification.

Parameters:
- A12_LOW_M2, 3, number of M2 (`ce`) pulses A12 must stay low before a rise is accepted (range 1..15).
- FILTER_EN, 1, 1 = low-time filter active; 0 = every sampled 0->1 transition of A12 is a rise.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  mapper enabled
- ce  in  1  M2 / CPU clock enable
- ppu_ce  in  1  PPU clock enable
- chr_ain_o  in  14  PPU CHR address (bit 12 used)
- chr_read  in  1  PPU CHR read strobe
- prg_write  in  1  CPU write strobe
- irq_mode  in  2  source select: 00 M2, 01 A12 rise, 10 CHR read, 11 CPU write
- cnt_clear  in  1  synchronous clear of tick_count
- irq_tick  out  1  one-clock event pulse to prescaler
- a12_rise  out  1  one-clock filtered A12 rise pulse (independent of irq_mode)
- a12_level  out  1  last A12 value sampled on ppu_ce
- tick_count  out  16  number of irq_tick pulses since reset/clear

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- Reset values:
  - irq_tick = 0, a12_rise = 0, a12_level = 0.
  - tick_count = 0, FSM = A12_HIGH, low_cnt = 0.
- A12 sampling: a12_level <= chr_ain_o[12] only on cycles with ppu_ce; the FSM evaluates the new sample in that same cycle.
- FSM states (FILTER_EN=1):
  - A12_HIGH: sampled 0 -> A12_LOW_WAIT, low_cnt <= 0.
  - A12_LOW_WAIT: each ce increments low_cnt.
    - low_cnt+1 == A12_LOW_M2 -> A12_ARMED.
    - Sampled 1 (ppu_ce) -> A12_HIGH, no rise.
  - A12_ARMED: sampled 1 -> A12_HIGH and a12_rise=1 next cycle; sampled 0 -> stay.
  - Simultaneous ce and ppu_ce with sample=1 in A12_LOW_WAIT: the sample wins -> A12_HIGH, no rise, even if the count would have completed that cycle.
  - low_cnt is 4 bits, saturating; it only counts in A12_LOW_WAIT.
- FILTER_EN=0: a12_rise pulses when a ppu_ce sample is 1 and the previous sample was 0; the FSM and low_cnt are unused.
- Event select (combinational, then registered; irq_tick is high in the cycle after the event):
  - 00: ce
  - 01: filtered rise strobe (the same event that drives a12_rise)
  - 10: ppu_ce && chr_read
  - 11: ce && prg_write
- Latency: one clk from qualifying input to irq_tick. A12 rise: irq_tick and a12_rise assert in the same cycle.
- Pulse width: irq_tick is never more than one cycle per qualifying event; back-to-back events give back-to-back pulses.
- irq_mode change: takes effect on the next event evaluation. No pending event is carried across a mode change. The A12 FSM runs regardless of irq_mode.
- enable=0:
  - FSM forced to A12_HIGH, low_cnt=0.
  - irq_tick=0, a12_rise=0.
  - a12_level still tracks A12.
  - tick_count holds.
- tick_count:
  - Increments by 1 on each cycle irq_tick is 1; wraps FFFF->0000.
  - cnt_clear has priority over increment (a cycle with both yields 0).
- Reset asserted mid-operation: all state returns to reset values immediately (async). No tick is issued on reset release.

Test Plan:
- Filtered rise: A12_LOW_M2=3, mode 01. Sample A12=0, give 3 ce pulses, then a ppu_ce with A12=1 -> exactly one a12_rise and one irq_tick, 1 clk later; tick_count=1.
- Glitch rejection: A12 low for only 2 ce pulses, then high -> no a12_rise, no irq_tick. A second low period of 3 ce pulses, then high -> one pulse.
- Collision: in A12_LOW_WAIT, the third ce and a ppu_ce sample of A12=1 land in the same cycle -> FSM to A12_HIGH, no rise.
- Mode 11 with 5 ce&&prg_write events and 5 ce-only cycles -> exactly 5 irq_tick pulses. Mode 00 over 10 ce pulses -> 10 pulses, tick_count advances by 10.
- Wrap/clear: preload via 65535 mode-00 ticks, then one more -> tick_count=0000. cnt_clear asserted in the same cycle as a tick -> tick_count=0.
- enable=0 mid-ARMED, then enable=1 with A12=1 -> no rise. Async reset_n pulse between clk edges -> outputs 0 immediately.

Source files
------------

// File: rtl/jy_irq_source.sv
// IRQ event conditioning for the J.Y. Company mapper: selects one bus event per cycle
// and registers it as a single irq_tick pulse. PPU A12 rises pass through a low-time filter.
module jy_irq_source #(
  parameter int unsigned A12_LOW_M2 = 3,
  parameter bit          FILTER_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce,
  input  logic        ppu_ce,
  input  logic [13:0] chr_ain_o,
  input  logic        chr_read,
  input  logic        prg_write,
  input  logic [1:0]  irq_mode,
  input  logic        cnt_clear,
  output logic        irq_tick,
  output logic        a12_rise,
  output logic        a12_level,
  output logic [15:0] tick_count,
  output logic [1:0]  a12_state
);

  typedef enum logic [1:0] {
    A12_HIGH     = 2'd0,
    A12_LOW_WAIT = 2'd1,
    A12_ARMED    = 2'd2
  } a12_state_e;

  localparam logic [4:0] LOW_TARGET = 5'(A12_LOW_M2);

  a12_state_e state_q, state_d;
  logic [3:0] low_cnt_q, low_cnt_d;
  logic       sample;
  logic       fsm_rise;
  logic       raw_rise;
  logic       rise_strobe;
  logic       event_sel;
  logic       unused_addr_bits;

  assign sample           = chr_ain_o[12];
  assign unused_addr_bits = ^{chr_ain_o[13], chr_ain_o[11:0]};
  assign a12_state        = state_q;

  // A rise from the ARMED state only; a high sample wins over a completing low count.
  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    fsm_rise  = 1'b0;
    if (!enable) begin
      state_d   = A12_HIGH;
      low_cnt_d = 4'd0;
    end else begin
      case (state_q)
        A12_HIGH: begin
          if (ppu_ce && !sample) begin
            state_d   = A12_LOW_WAIT;
            low_cnt_d = 4'd0;
          end
        end
        A12_LOW_WAIT: begin
          if (ppu_ce && sample) begin
            state_d = A12_HIGH;
          end else if (ce) begin
            if (low_cnt_q != 4'hF) low_cnt_d = low_cnt_q + 4'd1;
            if ({1'b0, low_cnt_q} + 5'd1 == LOW_TARGET) state_d = A12_ARMED;
          end
        end
        A12_ARMED: begin
          if (ppu_ce && sample) begin
            state_d  = A12_HIGH;
            fsm_rise = 1'b1;
          end
        end
        default: state_d = A12_HIGH;
      endcase
    end
  end

  assign raw_rise    = enable && ppu_ce && sample && !a12_level;
  assign rise_strobe = FILTER_EN ? fsm_rise : raw_rise;

  always_comb begin
    event_sel = 1'b0;
    case (irq_mode)
      2'b00: event_sel = ce;
      2'b01: event_sel = rise_strobe;
      2'b10: event_sel = ppu_ce && chr_read;
      2'b11: event_sel = ce && prg_write;
      default: event_sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= A12_HIGH;
      low_cnt_q  <= 4'd0;
      a12_level  <= 1'b0;
      a12_rise   <= 1'b0;
      irq_tick   <= 1'b0;
      tick_count <= 16'd0;
    end else begin
      state_q   <= state_d;
      low_cnt_q <= low_cnt_d;
      if (ppu_ce) a12_level <= sample;
      a12_rise <= rise_strobe;
      irq_tick <= enable && event_sel;
      if (cnt_clear)     tick_count <= 16'd0;
      else if (irq_tick) tick_count <= tick_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_jy_irq_source.sv
// Directed bench for jy_irq_source: filtered A12 rises, source selection, counter wrap/clear,
// enable gating and asynchronous reset.
module tb_jy_irq_source;

  localparam logic [1:0] S_HIGH  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        ce;
  logic        ppu_ce;
  logic [13:0] chr_ain_o;
  logic        chr_read;
  logic        prg_write;
  logic [1:0]  irq_mode;
  logic        cnt_clear;
  logic        irq_tick;
  logic        a12_rise;
  logic        a12_level;
  logic [15:0] tick_count;
  logic [1:0]  a12_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt;

  jy_irq_source #(.A12_LOW_M2(3), .FILTER_EN(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .ce         (ce),
    .ppu_ce     (ppu_ce),
    .chr_ain_o  (chr_ain_o),
    .chr_read   (chr_read),
    .prg_write  (prg_write),
    .irq_mode   (irq_mode),
    .cnt_clear  (cnt_clear),
    .irq_tick   (irq_tick),
    .a12_rise   (a12_rise),
    .a12_level  (a12_level),
    .tick_count (tick_count),
    .a12_state  (a12_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ce(input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1;
      step();
      ce = 1'b0;
      step();
    end
  endtask

  task automatic sample_a12(input logic v);
    chr_ain_o[12] = v;
    ppu_ce = 1'b1;
    step();
    ppu_ce = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; ce = 1'b0; ppu_ce = 1'b0; chr_ain_o = 14'h0;
    chr_read = 1'b0; prg_write = 1'b0; irq_mode = 2'b00; cnt_clear = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL reset_irq_tick got=%b exp=0", irq_tick); end
    checks++; if (a12_rise !== 1'b0) begin errors++; $display("FAIL reset_a12_rise got=%b exp=0", a12_rise); end
    checks++; if (a12_level !== 1'b0) begin errors++; $display("FAIL reset_a12_level got=%b exp=0", a12_level); end
    checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL reset_tick_count got=%0d exp=0", tick_count); end
    checks++; if (a12_state !== S_HIGH) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", a12_state, S_HIGH); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_filtered_rise();
    enable = 1'b1; irq_mode = 2'b01;
    sample_a12(1'b0);
    checks++; if (a12_state !== S_WAIT) begin errors++; $display("FAIL rise_enter_wait got=%0d exp=%0d", a12_state, S_WAIT); end
    pulse_ce(2);
    checks++; if (a12_state !== S_WAIT) begin errors++; $display("FAIL rise_still_wait got=%0d exp=%0d", a12_state, S_WAIT); end
    pulse_ce(1);
    checks++; if (a12_state !== S_ARMED) begin errors++; $display("FAIL rise_armed got=%0d exp=%0d", a12_state, S_ARMED); end
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL rise_no_tick_on_ce got=%b exp=0", irq_tick); end
    sample_a12(1'b1);
    checks++; if (a12_rise !== 1'b1) begin errors++; $display("FAIL rise_pulse got=%b exp=1", a12_rise); end
    checks++; if (irq_tick !== 1'b1) begin errors++; $display("FAIL rise_tick got=%b exp=1", irq_tick); end
    checks++; if (a12_level !== 1'b1) begin errors++; $display("FAIL rise_level got=%b exp=1", a12_level); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (a12_rise !== 1'b0) begin errors++; $display("FAIL rise_single got=%b exp=0", a12_rise); end
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL rise_tick_single got=%b exp=0", irq_tick); end
    checks++; if (tick_count !== exp_cnt) begin errors++; $display("FAIL rise_count got=%0d exp=%0d", tick_count, exp_cnt); end
  endtask

  task automatic test_glitch();
    sample_a12(1'b0);
    pulse_ce(2);
    sample_a12(1'b1);
    checks++; if (a12_rise !== 1'b0) begin errors++; $display("FAIL glitch_rise got=%b exp=0", a12_rise); end
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL glitch_tick got=%b exp=0", irq_tick); end
    checks++; if (a12_state !== S_HIGH) begin errors++; $display("FAIL glitch_state got=%0d exp=%0d", a12_state, S_HIGH); end
    sample_a12(1'b0);
    pulse_ce(3);
    sample_a12(1'b1);
    checks++; if (a12_rise !== 1'b1) begin errors++; $display("FAIL glitch_second_rise got=%b exp=1", a12_rise); end
    checks++; if (irq_tick !== 1'b1) begin errors++; $display("FAIL glitch_second_tick got=%b exp=1", irq_tick); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (tick_count !== exp_cnt) begin errors++; $display("FAIL glitch_count got=%0d exp=%0d", tick_count, exp_cnt); end
  endtask

  task automatic test_collision();
    sample_a12(1'b0);
    pulse_ce(2);
    ce = 1'b1; ppu_ce = 1'b1; chr_ain_o[12] = 1'b1;
    step();
    ce = 1'b0; ppu_ce = 1'b0;
    checks++; if (a12_state !== S_HIGH) begin errors++; $display("FAIL collide_state got=%0d exp=%0d", a12_state, S_HIGH); end
    checks++; if (a12_rise !== 1'b0) begin errors++; $display("FAIL collide_rise got=%b exp=0", a12_rise); end
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL collide_tick got=%b exp=0", irq_tick); end
    step();
    checks++; if (tick_count !== exp_cnt) begin errors++; $display("FAIL collide_count got=%0d exp=%0d", tick_count, exp_cnt); end
  endtask

  task automatic test_mode_write();
    int seen;
    logic exp_tick;
    seen = 0;
    irq_mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      ce = 1'b1;
      prg_write = (i % 2 == 0);
      exp_tick = (i % 2 == 0);
      step();
      if (irq_tick === 1'b1) seen++;
      checks++; if (irq_tick !== exp_tick) begin errors++; $display("FAIL mode11_cycle%0d got=%b exp=%b", i, irq_tick, exp_tick); end
    end
    ce = 1'b0; prg_write = 1'b0;
    step();
    exp_cnt = exp_cnt + 16'd5;
    checks++; if (seen != 5) begin errors++; $display("FAIL mode11_pulses got=%0d exp=5", seen); end
    checks++; if (tick_count !== exp_cnt) begin errors++; $display("FAIL mode11_count got=%0d exp=%0d", tick_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    irq_mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      ce = 1'b1;
      step();
      checks++; if (irq_tick !== 1'b1) begin errors++; $display("FAIL mode00_cycle%0d got=%b exp=1", i, irq_tick); end
    end
    ce = 1'b0;
    step();
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL mode00_idle got=%b exp=0", irq_tick); end
    exp_cnt = exp_cnt + 16'd10;
    checks++; if (tick_count !== exp_cnt) begin errors++; $display("FAIL mode00_count got=%0d exp=%0d", tick_count, exp_cnt); end
  endtask

  task automatic test_chr_read();
    irq_mode = 2'b10;
    chr_read = 1'b1; ppu_ce = 1'b0;
    step();
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL mode10_no_ce got=%b exp=0", irq_tick); end
    ppu_ce = 1'b1;
    step();
    checks++; if (irq_tick !== 1'b1) begin errors++; $display("FAIL mode10_tick got=%b exp=1", irq_tick); end
    ppu_ce = 1'b0; chr_read = 1'b0;
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (tick_count !== exp_cnt) begin errors++; $display("FAIL mode10_count got=%0d exp=%0d", tick_count, exp_cnt); end
  endtask

  task automatic test_wrap_clear();
    irq_mode = 2'b00;
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", tick_count); end
    ce = 1'b1;
    repeat (65535) step();
    ce = 1'b0;
    step();
    checks++; if (tick_count !== 16'hFFFF) begin errors++; $display("FAIL preload_count got=%h exp=ffff", tick_count); end
    ce = 1'b1;
    step();
    ce = 1'b0;
    step();
    checks++; if (tick_count !== 16'h0000) begin errors++; $display("FAIL wrap_count got=%h exp=0000", tick_count); end
    ce = 1'b1;
    step();
    step();
    ce = 1'b0; cnt_clear = 1'b1;
    checks++; if (irq_tick !== 1'b1) begin errors++; $display("FAIL clear_setup_tick got=%b exp=1", irq_tick); end
    step();
    cnt_clear = 1'b0;
    checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL clear_priority got=%0d exp=0", tick_count); end
    step();
    checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL clear_hold got=%0d exp=0", tick_count); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_enable();
    irq_mode = 2'b01;
    sample_a12(1'b0);
    pulse_ce(3);
    checks++; if (a12_state !== S_ARMED) begin errors++; $display("FAIL en_armed got=%0d exp=%0d", a12_state, S_ARMED); end
    enable = 1'b0;
    step();
    checks++; if (a12_state !== S_HIGH) begin errors++; $display("FAIL en_forced_high got=%0d exp=%0d", a12_state, S_HIGH); end
    sample_a12(1'b1);
    checks++; if (a12_level !== 1'b1) begin errors++; $display("FAIL en_level_track1 got=%b exp=1", a12_level); end
    sample_a12(1'b0);
    checks++; if (a12_level !== 1'b0) begin errors++; $display("FAIL en_level_track0 got=%b exp=0", a12_level); end
    irq_mode = 2'b00; ce = 1'b1;
    step();
    ce = 1'b0;
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL en_tick_gated got=%b exp=0", irq_tick); end
    irq_mode = 2'b01;
    enable = 1'b1;
    sample_a12(1'b1);
    checks++; if (a12_rise !== 1'b0) begin errors++; $display("FAIL en_no_rise got=%b exp=0", a12_rise); end
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL en_no_tick got=%b exp=0", irq_tick); end
    step();
    checks++; if (tick_count !== exp_cnt) begin errors++; $display("FAIL en_count_hold got=%0d exp=%0d", tick_count, exp_cnt); end
  endtask

  task automatic test_async_reset();
    irq_mode = 2'b00;
    ce = 1'b1;
    step();
    step();
    checks++; if (irq_tick !== 1'b1 || tick_count !== 16'd1) begin
      errors++; $display("FAIL areset_setup got=%b/%0d exp=1/1", irq_tick, tick_count);
    end
    ce = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL areset_tick got=%b exp=0", irq_tick); end
    checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", tick_count); end
    checks++; if (a12_level !== 1'b0) begin errors++; $display("FAIL areset_level got=%b exp=0", a12_level); end
    #1 reset_n = 1'b1;
    step();
    checks++; if (irq_tick !== 1'b0) begin errors++; $display("FAIL areset_release_tick got=%b exp=0", irq_tick); end
    checks++; if (a12_state !== S_HIGH) begin errors++; $display("FAIL areset_state got=%0d exp=%0d", a12_state, S_HIGH); end
  endtask

  initial begin
    test_reset();
    test_filtered_rise();
    test_glitch();
    test_collision();
    test_mode_write();
    test_back_to_back();
    test_chr_read();
    test_wrap_clear();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
